// File: rtl/reg_field_encoder.sv
// Packs a destination/pointer register address pair into the 4-bit R field,
// tags pairs outside the register windows, and queues results in a 2-deep FIFO.
module reg_field_encoder #(
  parameter logic [1:0] RD_PREFIX = 2'b11,
  parameter logic [1:0] RP_PREFIX = 2'b10,
  parameter int         CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_rd,
  input  logic [3:0]       in_rp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_r,
  output logic             out_err,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky
);

  typedef struct packed {
    logic       err;
    logic [3:0] r;
  } entry_t;

  entry_t     mem [2];
  entry_t     in_entry;
  entry_t     head;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  assign in_entry.r   = {in_rd[1:0], in_rp[1:0]};
  assign in_entry.err = (in_rd[3:2] != RD_PREFIX) || (in_rp[3:2] != RP_PREFIX);

  // Readiness depends only on registered occupancy, so a full FIFO never
  // passes a pair straight through on a same-cycle pop.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head    = out_valid ? mem[rd_ptr] : '0;
  assign out_r   = head.r;
  assign out_err = head.err;

  // NOTE: storage has no reset; stale entries are never visible because the
  // head is masked by out_valid, which comes from the reset occupancy count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Clear beats a same-cycle increment; a same-cycle accepted error still
  // leaves the sticky flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_cnt    <= '0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (clr_stats) begin
      enc_cnt    <= '0;
      err_cnt    <= '0;
      err_sticky <= push && in_entry.err;
    end else if (push) begin
      if (in_entry.err) begin
        err_sticky <= 1'b1;
        if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
      end else if (enc_cnt != {CNT_W{1'b1}}) begin
        enc_cnt <= enc_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_field_encoder.sv
// Self-checking bench for reg_field_encoder: encode vectors, backpressure and
// reset corner cases, counter saturation, and a randomized scoreboard run.
module tb_reg_field_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_rd;
  logic [3:0] in_rp;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_r;
  logic       out_err;
  logic       clr_stats;
  logic [7:0] enc_cnt;
  logic [7:0] err_cnt;
  logic       err_sticky;

  int passed = 0;
  int total  = 0;

  reg_field_encoder #(.RD_PREFIX(2'b11), .RP_PREFIX(2'b10), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_rp(in_rp),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_err(out_err),
    .clr_stats(clr_stats), .enc_cnt(enc_cnt), .err_cnt(err_cnt), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rd;
    logic [3:0] rp;
    logic [3:0] exp_r;
    logic       exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_stats = 1'b0;
    in_rd     = 4'h0;
    in_rp     = 4'h0;
    rst_n     = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // Reference encoding from the address-window rules, in plain arithmetic.
  function automatic logic [4:0] model_enc(input int rd, input int rp);
    int r;
    bit e;
    r = (rd % 4) * 4 + (rp % 4);
    e = (rd / 4 != 3) || (rp / 4 != 2);
    return {e, r[3:0]};
  endfunction

  initial begin
    vec_t vecs[8];
    logic [4:0] exp_q[$];
    logic [4:0] exp_e;
    logic [4:0] saved;
    int m_enc, m_err, sent, got, cyc, rd_i, rp_i;
    bit acc, pp, stall;

    vecs[0] = '{4'hD, 4'h9, 4'b0101, 1'b0};
    vecs[1] = '{4'hC, 4'h8, 4'b0000, 1'b0};
    vecs[2] = '{4'hF, 4'hB, 4'b1111, 1'b0};
    vecs[3] = '{4'h3, 4'hA, 4'b1110, 1'b1};
    vecs[4] = '{4'hB, 4'hB, 4'b1111, 1'b1};
    vecs[5] = '{4'hC, 4'hC, 4'b0000, 1'b1};
    vecs[6] = '{4'h0, 4'h0, 4'b0000, 1'b1};
    vecs[7] = '{4'h7, 4'h5, 4'b1101, 1'b1};

    // Reset state
    in_valid = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
    in_rd = 4'h0; in_rp = 4'h0; rst_n = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_r", out_r, 0);
    check("rst_out_err", out_err, 0);
    check("rst_enc_cnt", enc_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_sticky", err_sticky, 0);
    do_reset();

    // Single-pair vectors from an empty FIFO: 1-cycle latency, then drain.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_rd = vecs[i].rd; in_rp = vecs[i].rp;
      step();
      in_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_r", i), out_r, vecs[i].exp_r);
      check($sformatf("vec%0d_err", i), out_err, vecs[i].exp_err);
      step();
      check($sformatf("vec%0d_drained", i), out_valid, 0);
    end
    check("vec_enc_cnt", enc_cnt, 3);
    check("vec_err_cnt", err_cnt, 5);
    check("vec_sticky", err_sticky, 1);

    // Backpressure: two accepted, third stalled until the first pop.
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_rd = 4'hF; in_rp = 4'h8; step();
    in_rd = 4'hC; in_rp = 4'hB; step();
    in_rd = 4'hE; in_rp = 4'h9;
    check("bp_full_ready", in_ready, 0);
    check("bp_head", out_r, 4'b1100);
    step();
    check("bp_still_full", in_ready, 0);
    check("bp_head_hold", out_r, 4'b1100);
    out_ready = 1'b1;
    step();
    check("bp_ready_after_pop", in_ready, 1);
    check("bp_second", out_r, 4'b0011);
    step();
    in_valid = 1'b0;
    check("bp_third", out_r, 4'b1001);
    check("bp_third_valid", out_valid, 1);
    step();
    check("bp_empty", out_valid, 0);
    check("bp_enc_cnt", enc_cnt, 3);

    // Streaming at full rate; enc_cnt saturates.
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rd_i = 12 + int'($urandom_range(0, 3));
      rp_i = 8 + int'($urandom_range(0, 3));
      in_rd = rd_i[3:0]; in_rp = rp_i[3:0];
      exp_e = model_enc(rd_i, rp_i);
      check("stream_ready", in_ready, 1);
      step();
      check("stream_out", {out_valid, out_err, out_r}, {1'b1, exp_e});
    end
    check("stream_enc_sat", enc_cnt, 255);
    check("stream_err_cnt", err_cnt, 0);

    // Clear concurrent with an accepted error: cleared count, sticky set.
    clr_stats = 1'b1; in_rd = 4'h3; in_rp = 4'hA;
    step();
    clr_stats = 1'b0; in_valid = 1'b0;
    check("clr_err_cnt", err_cnt, 0);
    check("clr_enc_cnt", enc_cnt, 0);
    check("clr_sticky_set", err_sticky, 1);
    check("clr_fifo_kept", {out_valid, out_err, out_r}, {1'b1, 1'b1, 4'b1110});
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    check("clr_sticky_clear", err_sticky, 0);

    // Asynchronous reset mid-cycle with the FIFO full.
    do_reset();
    in_valid = 1'b1;
    in_rd = 4'hF; in_rp = 4'h8; step();
    in_rd = 4'h1; in_rp = 4'h8; step();
    in_valid = 1'b0;
    check("mr_full", in_ready, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("mr_out_valid", out_valid, 0);
    check("mr_in_ready", in_ready, 1);
    check("mr_out", {out_err, out_r}, 0);
    check("mr_cnts", {enc_cnt, err_cnt, err_sticky}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_rd = 4'hD; in_rp = 4'h9;
    step();
    in_valid = 1'b0;
    check("mr_after_out", {out_valid, out_err, out_r}, {1'b1, 1'b0, 4'b0101});
    check("mr_after_ready", in_ready, 1);
    check("mr_after_enc", enc_cnt, 1);

    // Randomized valid/ready against a queue scoreboard.
    do_reset();
    m_enc = 0; m_err = 0; sent = 0; got = 0; cyc = 0;
    while (got < 10000 && cyc < 60000) begin
      in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rd_i = int'($urandom_range(0, 15));
      rp_i = int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        rd_i = 12 + rd_i % 4;
        rp_i = 8 + rp_i % 4;
      end
      in_rd = rd_i[3:0]; in_rp = rp_i[3:0];
      #1;
      check("rnd_ready", in_ready, exp_q.size() != 2);
      check("rnd_valid", out_valid, exp_q.size() != 0);
      acc   = in_valid && in_ready;
      pp    = out_valid && out_ready;
      stall = out_valid && !out_ready;
      saved = {out_err, out_r};
      if (pp) begin
        if (exp_q.size() == 0) check("rnd_pop_empty", 1, 0);
        else check("rnd_pop", {out_err, out_r}, exp_q.pop_front());
        got++;
      end
      if (acc) begin
        exp_e = model_enc(rd_i, rp_i);
        exp_q.push_back(exp_e);
        if (exp_e[4]) m_err++;
        else m_enc++;
        sent++;
      end
      step();
      cyc++;
      if (stall) check("rnd_head_stable", {out_valid, out_err, out_r}, {1'b1, saved});
    end
    in_valid = 1'b0;
    check("rnd_done", got, 10000);
    check("rnd_enc_cnt", enc_cnt, (m_enc > 255) ? 255 : m_enc);
    check("rnd_err_cnt", err_cnt, (m_err > 255) ? 255 : m_err);
    check("rnd_sticky", err_sticky, m_err > 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
